// File: rtl/dma_job_scheduler.sv
// DMA job scheduler: queues DMA jobs and programs a register-mapped DMA
// engine one job at a time. Each job writes the engine's src, dest, size,
// tail, head and ctrl registers, waits for the completion interrupt, clears
// ctrl_stat and retires the job with a done pulse.
//
// Job handshake: a job transfers on every posedge where job_valid and
// job_ready are both 1. job_ready depends only on registered queue
// occupancy, never on job_valid. The offering side must hold job_valid and
// the job fields stable until the transfer happens.
module dma_job_scheduler #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [31:0]      job_src,
    input  logic [31:0]      job_dest,
    input  logic [31:0]      job_size,
    output logic [31:0]      reg_wr_data,
    output logic [5:0]       reg_wr_en,
    input  logic             eng_intr,
    output logic             done,
    output logic [CNT_W-1:0] done_count,
    output logic             busy,
    output logic [3:0]       fsm_state
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

    // Engine register strobes, one bit per register.
    localparam logic [5:0] EN_SRC  = 6'b000001;
    localparam logic [5:0] EN_DEST = 6'b000010;
    localparam logic [5:0] EN_TAIL = 6'b000100;
    localparam logic [5:0] EN_HEAD = 6'b001000;
    localparam logic [5:0] EN_SIZE = 6'b010000;
    localparam logic [5:0] EN_CTRL = 6'b100000;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W_SRC   = 4'd1,
        W_DEST  = 4'd2,
        W_SIZE  = 4'd3,
        W_TAIL  = 4'd4,
        W_HEAD  = 4'd5,
        W_START = 4'd6,
        WAIT    = 4'd7,
        CLEAR   = 4'd8,
        RETIRE  = 4'd9
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      q_src  [QDEPTH];
    logic [31:0]      q_dest [QDEPTH];
    logic [31:0]      q_size [QDEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop;

    logic [31:0]      cur_src, cur_dest, cur_size;

    assign job_ready = (count != FULL_CNT);
    assign push      = job_valid && job_ready;
    // The FSM takes the head entry whenever it sits in IDLE with work queued.
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);
    assign done      = (state == RETIRE);
    assign fsm_state = state;

    // Queue payload storage; entries need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            q_src[wr_ptr]  <= job_src;
            q_dest[wr_ptr] <= job_dest;
            q_size[wr_ptr] <= job_size;
        end
    end

    // Queue pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Latch the popped job so the queue slot can be reused immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_src  <= '0;
            cur_dest <= '0;
            cur_size <= '0;
        end else if (pop) begin
            cur_src  <= q_src[rd_ptr];
            cur_dest <= q_dest[rd_ptr];
            cur_size <= q_size[rd_ptr];
        end
    end

    // FSM state register; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Retired-job counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 done_count <= '0;
        else if (state == RETIRE) done_count <= done_count + 1'b1;
    end

    // Next state and engine register writes; writes are idle by default.
    always_comb begin
        state_nxt   = state;
        reg_wr_en   = '0;
        reg_wr_data = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    // Zero-byte jobs have nothing to move; retire them directly.
                    if (q_size[rd_ptr] == '0) state_nxt = RETIRE;
                    else                      state_nxt = W_SRC;
                end
            end
            W_SRC: begin
                reg_wr_en   = EN_SRC;
                reg_wr_data = cur_src;
                state_nxt   = W_DEST;
            end
            W_DEST: begin
                reg_wr_en   = EN_DEST;
                reg_wr_data = cur_dest;
                state_nxt   = W_SIZE;
            end
            W_SIZE: begin
                reg_wr_en   = EN_SIZE;
                reg_wr_data = cur_size;
                state_nxt   = W_TAIL;
            end
            W_TAIL: begin
                reg_wr_en   = EN_TAIL;
                reg_wr_data = '0;
                state_nxt   = W_HEAD;
            end
            W_HEAD: begin
                reg_wr_en   = EN_HEAD;
                reg_wr_data = cur_size;
                state_nxt   = W_START;
            end
            W_START: begin
                reg_wr_en   = EN_CTRL;
                reg_wr_data = 32'h0000_0001;
                state_nxt   = WAIT;
            end
            WAIT: begin
                // Only an interrupt seen here counts; earlier ones are stale.
                if (eng_intr) state_nxt = CLEAR;
            end
            CLEAR: begin
                reg_wr_en   = EN_CTRL;
                reg_wr_data = '0;
                state_nxt   = RETIRE;
            end
            RETIRE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Testbench for dma_job_scheduler: directed jobs, a transaction-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_dma_job_scheduler;

    localparam int QDEPTH = 4;
    localparam int CNT_W  = 2;

    logic             clk;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic [31:0]      job_src;
    logic [31:0]      job_dest;
    logic [31:0]      job_size;
    logic [31:0]      reg_wr_data;
    logic [5:0]       reg_wr_en;
    logic             eng_intr;
    logic             done;
    logic [CNT_W-1:0] done_count;
    logic             busy;
    logic [3:0]       fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    dma_job_scheduler #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_src    (job_src),
        .job_dest   (job_dest),
        .job_size   (job_size),
        .reg_wr_data(reg_wr_data),
        .reg_wr_en  (reg_wr_en),
        .eng_intr   (eng_intr),
        .done       (done),
        .done_count (done_count),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait expired, got no event, required event (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Jobs waiting to be started, and the per-cycle output schedule of the
    // job in flight. Schedule word: [39] wait-for-interrupt marker,
    // [38] done, [37:32] register strobe, [31:0] register data.
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] size;
    } job_t;

    job_t             mq[$];
    logic [39:0]      exp_q[$];
    logic [CNT_W-1:0] m_count;

    function automatic logic [39:0] ev(input logic w, input logic d,
                                       input logic [5:0] en, input logic [31:0] data);
        return {w, d, en, data};
    endfunction

    task automatic schedule(input job_t j);
        if (j.size == 32'd0) begin
            exp_q.push_back(ev(1'b0, 1'b1, 6'd0, 32'd0));
        end else begin
            exp_q.push_back(ev(1'b0, 1'b0, 6'b000001, j.src));
            exp_q.push_back(ev(1'b0, 1'b0, 6'b000010, j.dest));
            exp_q.push_back(ev(1'b0, 1'b0, 6'b010000, j.size));
            exp_q.push_back(ev(1'b0, 1'b0, 6'b000100, 32'd0));
            exp_q.push_back(ev(1'b0, 1'b0, 6'b001000, j.size));
            exp_q.push_back(ev(1'b0, 1'b0, 6'b100000, 32'd1));
            exp_q.push_back(ev(1'b1, 1'b0, 6'd0, 32'd0));
            exp_q.push_back(ev(1'b0, 1'b0, 6'b100000, 32'd0));
            exp_q.push_back(ev(1'b0, 1'b1, 6'd0, 32'd0));
        end
    endtask

    // Observation logs used by the directed scenarios.
    logic [37:0]      strobe_log[$];
    int               done_log[$];
    logic [CNT_W-1:0] dc_log[$];
    logic             prev_done = 1'b0;

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin : compare_proc
        logic [39:0] e;
        bit          idle_now;
        bit          ready_now;
        job_t        j;
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            m_count   = '0;
            prev_done = 1'b0;
            check("rst_reg_wr_en",   reg_wr_en,   64'd0);
            check("rst_reg_wr_data", reg_wr_data, 64'd0);
            check("rst_done",        done,        64'd0);
            check("rst_busy",        busy,        64'd0);
            check("rst_done_count",  done_count,  64'd0);
            check("rst_job_ready",   job_ready,   64'd1);
        end else begin
            if (prev_done) dc_log.push_back(done_count);
            if (reg_wr_en != 6'd0) strobe_log.push_back({reg_wr_en, reg_wr_data});
            if (done) done_log.push_back(cyc);
            prev_done = done;

            idle_now  = (exp_q.size() == 0);
            e         = idle_now ? 40'd0 : exp_q[0];
            ready_now = (mq.size() < QDEPTH);

            check("reg_wr_en",   reg_wr_en,   {58'd0, e[37:32]});
            check("reg_wr_data", reg_wr_data, {32'd0, e[31:0]});
            check("done",        done,        {63'd0, e[38]});
            check("job_ready",   job_ready,   {63'd0, ready_now});
            check("busy",        busy,        {63'd0, (!idle_now || mq.size() != 0)});
            check("done_count",  done_count,  {{(64-CNT_W){1'b0}}, m_count});

            // Advance the model across the coming posedge.
            if (!idle_now) begin
                if (!e[39] || eng_intr) void'(exp_q.pop_front());
                if (e[38]) m_count = m_count + 1'b1;
            end else if (mq.size() != 0) begin
                j = mq.pop_front();
                schedule(j);
            end
            if (job_valid && ready_now) mq.push_back({job_src, job_dest, job_size});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z,
                            output int acc_cyc);
        logic r;
        bit   ok;
        ok        = 1'b0;
        acc_cyc   = -1;
        job_valid = 1'b1;
        job_src   = s;
        job_dest  = d;
        job_size  = z;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r       = job_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        job_valid = 1'b0;
        if (!ok) timeout_fail("push_job");
    endtask

    task automatic pulse_intr();
        eng_intr = 1'b1;
        @(posedge clk);
        #1;
        eng_intr = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (strobe_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_strobes");
    endtask

    task automatic wait_done(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_done");
    endtask

    // Wait for the next ctrl start write, answer with an interrupt after
    // d cycles, then wait for that job's done pulse.
    task automatic serve_one(input int d);
        bit ok;
        int n0;
        n0 = done_log.size();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (reg_wr_en == 6'b100000 && reg_wr_data == 32'd1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("serve_start");
        @(posedge clk);
        #1;
        repeat (d) begin
            @(posedge clk);
            #1;
        end
        pulse_intr();
        wait_done(n0 + 1);
    endtask

    task automatic clear_logs();
        strobe_log.delete();
        done_log.delete();
        dc_log.delete();
    endtask

    task automatic check_job_strobes(input string name, input logic [31:0] s,
                                     input logic [31:0] d, input logic [31:0] z);
        logic [5:0]  en_exp   [7];
        logic [31:0] data_exp [7];
        en_exp   = '{6'h01, 6'h02, 6'h10, 6'h04, 6'h08, 6'h20, 6'h20};
        data_exp = '{s, d, z, 32'd0, z, 32'd1, 32'd0};
        check({name, "_strobe_count"}, strobe_log.size(), 64'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < strobe_log.size()) begin
                check($sformatf("%s_en%0d", name, i),   strobe_log[i][37:32], {58'd0, en_exp[i]});
                check($sformatf("%s_data%0d", name, i), strobe_log[i][31:0],  {32'd0, data_exp[i]});
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    int               acc;
    int               a5;
    int               w_cyc;
    bit               j5_acc;
    logic [CNT_W-1:0] wrap_exp [5];

    initial begin
        rst       = 1'b0;
        job_valid = 1'b0;
        job_src   = '0;
        job_dest  = '0;
        job_size  = '0;
        eng_intr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_job_ready",  job_ready,  64'd1);
        check("reset_busy",       busy,       64'd0);
        check("reset_done_count", done_count, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single job, interrupt 10 cycles after the start write.
        clear_logs();
        push_job(32'h1000, 32'h2000, 32'h40, acc);
        wait_strobes(6);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        w_cyc = cyc;
        pulse_intr();
        wait_done(1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_job_strobes("single", 32'h1000, 32'h2000, 32'h40);
        check("single_done_pulses",  done_log.size(), 64'd1);
        if (done_log.size() > 0) check("single_done_latency", done_log[0] - w_cyc, 64'd2);
        check("single_done_count",   done_count, 64'd1);
        check("single_idle_busy",    busy, 64'd0);

        // Zero-size job: no strobes, done two cycles after the accept.
        clear_logs();
        push_job(32'h5555, 32'h6666, 32'h0, acc);
        wait_done(1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("zero_strobe_count", strobe_log.size(), 64'd0);
        if (done_log.size() > 0) check("zero_done_latency", done_log[0] - acc, 64'd2);
        check("zero_done_count", done_count, 64'd2);

        // Interrupt during W_DEST must be ignored.
        clear_logs();
        push_job(32'h3000, 32'h4000, 32'h10, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        pulse_intr();
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("spur_no_done",      done_log.size(),   64'd0);
        check("spur_still_busy",   busy,              64'd1);
        check("spur_strobes_so_far", strobe_log.size(), 64'd6);
        pulse_intr();
        wait_done(1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_job_strobes("spur", 32'h3000, 32'h4000, 32'h10);
        check("spur_done_count", done_count, 64'd3);

        // Queue full: one job parked in WAIT, four more fill the queue.
        clear_logs();
        push_job(32'h10, 32'h20, 32'h8, acc);
        for (int i = 1; i <= 4; i++) begin
            push_job(32'h100 * i, 32'h200 * i, 32'h4 * i, acc);
        end
        check("full_ready_low", job_ready, 64'd0);
        j5_acc = 1'b0;
        fork
            begin
                push_job(32'h500, 32'h600, 32'h14, a5);
                j5_acc = 1'b1;
            end
        join_none
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("full_fifth_stalled", j5_acc, 64'd0);
        check("full_ready_still_low", job_ready, 64'd0);
        pulse_intr();
        for (int i = 0; i < 40 && !j5_acc; i++) begin
            @(posedge clk);
            #1;
        end
        check("full_fifth_accepted", j5_acc, 64'd1);
        for (int i = 0; i < 5; i++) serve_one(2);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("full_done_pulses", done_log.size(), 64'd6);
        check("full_idle_busy", busy, 64'd0);

        // Reset while a job waits for its interrupt with two jobs queued.
        clear_logs();
        push_job(32'h7000, 32'h8000, 32'h20, acc);
        push_job(32'h7100, 32'h8100, 32'h30, acc);
        push_job(32'h7200, 32'h8200, 32'h40, acc);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("rstmid_busy_before", busy, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_reg_wr_en",   reg_wr_en,   64'd0);
        check("rstmid_reg_wr_data", reg_wr_data, 64'd0);
        check("rstmid_done",        done,        64'd0);
        check("rstmid_busy",        busy,        64'd0);
        check("rstmid_done_count",  done_count,  64'd0);
        check("rstmid_job_ready",   job_ready,   64'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        clear_logs();
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("rstmid_no_strobes", strobe_log.size(), 64'd0);
        check("rstmid_no_done",    done_log.size(),   64'd0);
        check("rstmid_busy_after", busy,              64'd0);

        // Counter wrap with a 2-bit counter: 1, 2, 3, 0, 1.
        clear_logs();
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            push_job(32'h0, 32'h0, 32'h0, acc);
            wait_done(i + 1);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("wrap_count_samples", dc_log.size(), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < dc_log.size())
                check($sformatf("wrap_done_count%0d", i), dc_log[i], {62'd0, wrap_exp[i]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
